// File: rtl/mem_controller.sv
// Sequencing controller for the Conv1D weight/input/output SRAMs: file load/dump phases and the MAC compute sweep.
// Optional debug ports (step counter, weight load index) appear only when MEMCTRL_DEBUG_PORTS_EN is defined.
module mem_controller #(
    parameter int Weight_Addr_Width               = 2,
    parameter int Output_Addr_Width               = 1,
    parameter int Input_Addr_Width                = 3,
    parameter int Nums_SRAM_In                    = 2,
    parameter int Nums_SRAM_Out                   = 1,
    parameter int Nums_SRAM                       = Nums_SRAM_In + Nums_SRAM_Out,
    parameter int Weight_Nums                     = 3,
    parameter int Output_Nums                     = 2,
    parameter int Input_Nums                      = Weight_Nums + Output_Nums - 1,
    parameter int Nums_Pipeline_Stages            = 4,
    parameter int Pipeline_Tail                   = Nums_Pipeline_Stages - 1,
    parameter int Total_Computation_Steps_in_bits = 6,
    parameter int Total_Computation_Steps         = Weight_Nums * Output_Nums + Pipeline_Tail
) (
    input  logic                                     clk,
    input  logic                                     Mem_Reset,
    input  logic                                     Comp_Reset,
    input  logic                                     Weight_Mem_Index_Reset,
    input  logic                                     Output_Mem_Index_Reset,
    input  logic                                     Input_Mem_Index_Reset,
    input  logic                                     Weight_Loading_Signal,
    input  logic                                     Input_Loading_Signal,
    input  logic                                     Output_Loading_Signal,
    input  logic                                     Output_Writing_Signal,
    input  logic                                     Computing_Signal,
`ifdef MEMCTRL_DEBUG_PORTS_EN
    output logic [Total_Computation_Steps_in_bits:0] Computation_Step_Counter,
    output logic [Weight_Addr_Width:0]               Weight_Mem_Index,
`endif
    output logic                                     Weight_Loading_From_File,
    output logic                                     Input_Loading_From_File,
    output logic                                     Output_Loading_From_File,
    output logic                                     Output_Writing_To_File,
    output logic                                     Computing,
    output logic                                     Initial_Accumulate,
    output logic [Nums_SRAM-1:0]                     Mem_Clear,
    output logic [Nums_SRAM-1:0]                     En_Chip_Select,
    output logic [Nums_SRAM-1:0]                     En_Write,
    output logic [Nums_SRAM-1:0]                     En_Read,
    output logic [Weight_Addr_Width-1:0]             Weight_Addr_Read,
    output logic [Weight_Addr_Width-1:0]             Weight_Addr_Write,
    output logic [Input_Addr_Width-1:0]              Input_Addr_Read,
    output logic [Input_Addr_Width-1:0]              Input_Addr_Write,
    output logic [Output_Addr_Width-1:0]             Output_Addr_Read,
    output logic [Output_Addr_Width-1:0]             Output_Addr_Write
);

    localparam int SW  = Total_Computation_Steps_in_bits + 1;
    localparam int WIW = Weight_Addr_Width + 1;
    localparam int IIW = Input_Addr_Width + 1;
    localparam int OIW = Output_Addr_Width + 1;

    localparam logic [SW-1:0]                STEP_LAST = SW'(Total_Computation_Steps - 1);
    localparam logic [SW-1:0]                RD_END    = SW'(Weight_Nums * Output_Nums);
    localparam logic [SW-1:0]                WB_START  = SW'(Pipeline_Tail);
    localparam logic [WIW-1:0]               W_LAST    = WIW'(Weight_Nums - 1);
    localparam logic [IIW-1:0]               I_LAST    = IIW'(Input_Nums - 1);
    localparam logic [OIW-1:0]               O_LAST    = OIW'(Output_Nums - 1);
    localparam logic [Weight_Addr_Width-1:0] TAP_LAST  = Weight_Addr_Width'(Weight_Nums - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LD_W = 3'd1;
    localparam logic [2:0] LD_I = 3'd2;
    localparam logic [2:0] LD_O = 3'd3;
    localparam logic [2:0] WR_O = 3'd4;
    localparam logic [2:0] COMP = 3'd5;

    logic [2:0]                   state, state_nxt;
    logic [WIW-1:0]               w_idx, w_idx_nxt;
    logic [IIW-1:0]               i_idx, i_idx_nxt;
    logic [OIW-1:0]               o_idx, o_idx_nxt;
    logic [SW-1:0]                step, step_nxt;
    // Tap/output counters for the read side and the lagging write-back side (avoids a divider).
    logic [Weight_Addr_Width-1:0] rd_k, rd_k_nxt, wb_k, wb_k_nxt;
    logic [Output_Addr_Width-1:0] rd_j, rd_j_nxt, wb_j, wb_j_nxt;

    always_comb begin
        state_nxt = state;
        w_idx_nxt = w_idx;
        i_idx_nxt = i_idx;
        o_idx_nxt = o_idx;
        step_nxt  = step;
        rd_k_nxt  = rd_k;
        rd_j_nxt  = rd_j;
        wb_k_nxt  = wb_k;
        wb_j_nxt  = wb_j;
        case (state)
            IDLE: begin
                if (Computing_Signal)           state_nxt = COMP;
                else if (Weight_Loading_Signal) state_nxt = LD_W;
                else if (Input_Loading_Signal)  state_nxt = LD_I;
                else if (Output_Loading_Signal) state_nxt = LD_O;
                else if (Output_Writing_Signal) state_nxt = WR_O;
            end
            LD_W: begin
                if (Weight_Mem_Index_Reset) w_idx_nxt = '0;
                else if (w_idx == W_LAST) begin
                    w_idx_nxt = '0;
                    state_nxt = IDLE;
                end else w_idx_nxt = w_idx + 1'b1;
            end
            LD_I: begin
                if (Input_Mem_Index_Reset) i_idx_nxt = '0;
                else if (i_idx == I_LAST) begin
                    i_idx_nxt = '0;
                    state_nxt = IDLE;
                end else i_idx_nxt = i_idx + 1'b1;
            end
            LD_O: begin
                if (Output_Mem_Index_Reset) o_idx_nxt = '0;
                else if (o_idx == O_LAST) begin
                    o_idx_nxt = '0;
                    state_nxt = IDLE;
                end else o_idx_nxt = o_idx + 1'b1;
            end
            WR_O: begin
                if (o_idx == O_LAST) begin
                    o_idx_nxt = '0;
                    state_nxt = IDLE;
                end else o_idx_nxt = o_idx + 1'b1;
            end
            COMP: begin
                if (Comp_Reset || step == STEP_LAST) begin
                    state_nxt = IDLE;
                    step_nxt  = '0;
                    rd_k_nxt  = '0;
                    rd_j_nxt  = '0;
                    wb_k_nxt  = '0;
                    wb_j_nxt  = '0;
                end else begin
                    step_nxt = step + 1'b1;
                    if (rd_k == TAP_LAST) begin
                        rd_k_nxt = '0;
                        rd_j_nxt = rd_j + 1'b1;
                    end else rd_k_nxt = rd_k + 1'b1;
                    // Write-back counters start advancing once the pipeline tail has elapsed.
                    if (step >= WB_START) begin
                        if (wb_k == TAP_LAST) begin
                            wb_k_nxt = '0;
                            wb_j_nxt = wb_j + 1'b1;
                        end else wb_k_nxt = wb_k + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic                 ldw_on, ldi_on, ldo_on, dump_on, rd_on, wb_on;
    logic [Nums_SRAM-1:0] rd_vec, wr_vec;

    always_comb begin
        ldw_on  = (state_nxt == LD_W);
        ldi_on  = (state_nxt == LD_I);
        ldo_on  = (state_nxt == LD_O);
        dump_on = (state_nxt == WR_O);
        rd_on   = (state_nxt == COMP) && (step_nxt < RD_END);
        wb_on   = (state_nxt == COMP) && (step_nxt >= WB_START);
        rd_vec    = '0;
        wr_vec    = '0;
        rd_vec[0] = rd_on;
        rd_vec[1] = rd_on;
        rd_vec[2] = rd_on | dump_on;
        wr_vec[0] = ldw_on;
        wr_vec[1] = ldi_on;
        wr_vec[2] = ldo_on | wb_on;
    end

    // Outputs are registered from next-state values so they line up with the phase they describe.
    always_ff @(posedge clk or negedge Mem_Reset) begin
        if (!Mem_Reset) begin
            state                    <= IDLE;
            w_idx                    <= '0;
            i_idx                    <= '0;
            o_idx                    <= '0;
            step                     <= '0;
            rd_k                     <= '0;
            rd_j                     <= '0;
            wb_k                     <= '0;
            wb_j                     <= '0;
            Weight_Loading_From_File <= 1'b0;
            Input_Loading_From_File  <= 1'b0;
            Output_Loading_From_File <= 1'b0;
            Output_Writing_To_File   <= 1'b0;
            Computing                <= 1'b0;
            Initial_Accumulate       <= 1'b0;
            Mem_Clear                <= '1;
            En_Chip_Select           <= '0;
            En_Write                 <= '0;
            En_Read                  <= '0;
            Weight_Addr_Read         <= '0;
            Weight_Addr_Write        <= '0;
            Input_Addr_Read          <= '0;
            Input_Addr_Write         <= '0;
            Output_Addr_Read         <= '0;
            Output_Addr_Write        <= '0;
        end else begin
            state                    <= state_nxt;
            w_idx                    <= w_idx_nxt;
            i_idx                    <= i_idx_nxt;
            o_idx                    <= o_idx_nxt;
            step                     <= step_nxt;
            rd_k                     <= rd_k_nxt;
            rd_j                     <= rd_j_nxt;
            wb_k                     <= wb_k_nxt;
            wb_j                     <= wb_j_nxt;
            Weight_Loading_From_File <= ldw_on;
            Input_Loading_From_File  <= ldi_on;
            Output_Loading_From_File <= ldo_on;
            Output_Writing_To_File   <= dump_on;
            Computing                <= (state_nxt == COMP);
            Initial_Accumulate       <= rd_on && (rd_k_nxt == '0);
            Mem_Clear                <= '0;
            En_Read                  <= rd_vec;
            En_Write                 <= wr_vec;
            En_Chip_Select           <= rd_vec | wr_vec;
            if (ldw_on) Weight_Addr_Write <= w_idx_nxt[Weight_Addr_Width-1:0];
            if (ldi_on) Input_Addr_Write  <= i_idx_nxt[Input_Addr_Width-1:0];
            if (ldo_on) Output_Addr_Write <= o_idx_nxt[Output_Addr_Width-1:0];
            else if (wb_on) Output_Addr_Write <= wb_j_nxt;
            if (rd_on) begin
                Weight_Addr_Read <= rd_k_nxt;
                Input_Addr_Read  <= Input_Addr_Width'(rd_j_nxt) + Input_Addr_Width'(rd_k_nxt);
                Output_Addr_Read <= rd_j_nxt;
            end else if (dump_on) begin
                Output_Addr_Read <= o_idx_nxt[Output_Addr_Width-1:0];
            end
        end
    end

`ifdef MEMCTRL_DEBUG_PORTS_EN
    assign Computation_Step_Counter = step;
    assign Weight_Mem_Index         = w_idx;
`endif

endmodule

// File: tb/tb_mem_controller.sv
// Randomized bench for mem_controller: a phase-level reference model queues expected per-cycle outputs,
// and a negedge monitor compares them whenever a phase strobe is active (idle cycles must be quiet).
module tb_mem_controller;

    localparam int W = 3;
    localparam int O = 2;
    localparam int I = W + O - 1;
    localparam int T = 3;
    localparam int S = W * O + T;

    logic       clk = 1'b0;
    logic       Mem_Reset, Comp_Reset;
    logic       Weight_Mem_Index_Reset, Output_Mem_Index_Reset, Input_Mem_Index_Reset;
    logic       Weight_Loading_Signal, Input_Loading_Signal, Output_Loading_Signal;
    logic       Output_Writing_Signal, Computing_Signal;
    logic       Weight_Loading_From_File, Input_Loading_From_File, Output_Loading_From_File;
    logic       Output_Writing_To_File, Computing, Initial_Accumulate;
    logic [2:0] Mem_Clear, En_Chip_Select, En_Write, En_Read;
    logic [1:0] Weight_Addr_Read, Weight_Addr_Write;
    logic [2:0] Input_Addr_Read, Input_Addr_Write;
    logic [0:0] Output_Addr_Read, Output_Addr_Write;
`ifdef MEMCTRL_DEBUG_PORTS_EN
    logic [6:0] Computation_Step_Counter;
    logic [2:0] Weight_Mem_Index;
`endif

    mem_controller dut (
        .clk(clk), .Mem_Reset(Mem_Reset), .Comp_Reset(Comp_Reset),
        .Weight_Mem_Index_Reset(Weight_Mem_Index_Reset),
        .Output_Mem_Index_Reset(Output_Mem_Index_Reset),
        .Input_Mem_Index_Reset(Input_Mem_Index_Reset),
        .Weight_Loading_Signal(Weight_Loading_Signal), .Input_Loading_Signal(Input_Loading_Signal),
        .Output_Loading_Signal(Output_Loading_Signal), .Output_Writing_Signal(Output_Writing_Signal),
        .Computing_Signal(Computing_Signal),
`ifdef MEMCTRL_DEBUG_PORTS_EN
        .Computation_Step_Counter(Computation_Step_Counter), .Weight_Mem_Index(Weight_Mem_Index),
`endif
        .Weight_Loading_From_File(Weight_Loading_From_File),
        .Input_Loading_From_File(Input_Loading_From_File),
        .Output_Loading_From_File(Output_Loading_From_File),
        .Output_Writing_To_File(Output_Writing_To_File), .Computing(Computing),
        .Initial_Accumulate(Initial_Accumulate), .Mem_Clear(Mem_Clear),
        .En_Chip_Select(En_Chip_Select), .En_Write(En_Write), .En_Read(En_Read),
        .Weight_Addr_Read(Weight_Addr_Read), .Weight_Addr_Write(Weight_Addr_Write),
        .Input_Addr_Read(Input_Addr_Read), .Input_Addr_Write(Input_Addr_Write),
        .Output_Addr_Read(Output_Addr_Read), .Output_Addr_Write(Output_Addr_Write)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] act;   // {comp, wr_o, ld_o, ld_i, ld_w}
        logic       ia;
        logic [2:0] mclr, rd, wr, cs;
        logic [1:0] war, waw;
        logic [2:0] iar, iaw;
        logic       oar, oaw;
        logic [6:0] step;
        logic [2:0] widx;
    } rec_t;

    rec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic mon_en = 1'b0;

    // Address registers hold their last enabled value; the model tracks them here.
    logic [1:0] h_war = '0, h_waw = '0;
    logic [2:0] h_iar = '0, h_iaw = '0;
    logic       h_oar = 1'b0, h_oaw = 1'b0;

    function automatic rec_t sample();
        rec_t r;
        r.act  = {Computing, Output_Writing_To_File, Output_Loading_From_File,
                  Input_Loading_From_File, Weight_Loading_From_File};
        r.ia   = Initial_Accumulate;
        r.mclr = Mem_Clear;
        r.rd   = En_Read;
        r.wr   = En_Write;
        r.cs   = En_Chip_Select;
        r.war  = Weight_Addr_Read;
        r.waw  = Weight_Addr_Write;
        r.iar  = Input_Addr_Read;
        r.iaw  = Input_Addr_Write;
        r.oar  = Output_Addr_Read;
        r.oaw  = Output_Addr_Write;
`ifdef MEMCTRL_DEBUG_PORTS_EN
        r.step = Computation_Step_Counter;
        r.widx = Weight_Mem_Index;
`else
        r.step = '0;
        r.widx = '0;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    function automatic void push_rec(input rec_t r_in);
        rec_t r;
        r     = r_in;
        r.cs  = r.rd | r.wr;
        r.war = h_war; r.waw = h_waw;
        r.iar = h_iar; r.iaw = h_iaw;
        r.oar = h_oar; r.oaw = h_oaw;
`ifndef MEMCTRL_DEBUG_PORTS_EN
        r.step = '0;
        r.widx = '0;
`endif
        exp_q.push_back(r);
    endfunction

    // pulses: {wr_o, ld_o, ld_i, ld_w, comp}; noise: start pulses held during the busy phase.
    task automatic run_op(input logic [4:0] pulses, input logic [4:0] noise,
                          input int abort_at, input int rst_sel);
        int   op, n, nn, idx, rst_at;
        rec_t r;
        op = pulses[0] ? 0 : pulses[1] ? 1 : pulses[2] ? 2 : pulses[3] ? 3 : 4;
        n  = 0;
        rst_at = -1;
        if (op == 0) begin
            n = (abort_at >= 0 && abort_at < S) ? abort_at + 1 : S;
            for (int s = 0; s < n; s++) begin
                r = '0;
                r.act  = 5'b10000;
                r.step = 7'(s);
                if (s < W * O) begin
                    r.rd  = 3'b111;
                    r.ia  = (s % W == 0);
                    h_war = 2'(s % W);
                    h_iar = 3'(s / W + s % W);
                    h_oar = 1'(s / W);
                end
                if (s >= T) begin
                    r.wr[2] = 1'b1;
                    h_oaw   = 1'((s - T) / W);
                end
                push_rec(r);
            end
        end else begin
            nn = (op == 1) ? W : (op == 2) ? I : O;
            if (op != 4 && rst_sel >= 0) rst_at = rst_sel % nn;
            idx = 0;
            while (1) begin
                r = '0;
                case (op)
                    1: begin r.act = 5'b00001; r.wr = 3'b001; h_waw = 2'(idx); r.widx = 3'(idx); end
                    2: begin r.act = 5'b00010; r.wr = 3'b010; h_iaw = 3'(idx); end
                    3: begin r.act = 5'b00100; r.wr = 3'b100; h_oaw = 1'(idx); end
                    default: begin r.act = 5'b01000; r.rd = 3'b100; h_oar = 1'(idx); end
                endcase
                push_rec(r);
                n++;
                if (n - 1 == rst_at) idx = 0;
                else if (idx == nn - 1) break;
                else idx++;
            end
        end
        {Output_Writing_Signal, Output_Loading_Signal, Input_Loading_Signal,
         Weight_Loading_Signal, Computing_Signal} = pulses;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            {Output_Writing_Signal, Output_Loading_Signal, Input_Loading_Signal,
             Weight_Loading_Signal, Computing_Signal} = noise;
            Comp_Reset             = (op == 0 && k == abort_at);
            Weight_Mem_Index_Reset = (op == 1 && k == rst_at);
            Input_Mem_Index_Reset  = (op == 2 && k == rst_at);
            Output_Mem_Index_Reset = (op == 3 && k == rst_at);
            @(posedge clk); #1;
        end
        {Output_Writing_Signal, Output_Loading_Signal, Input_Loading_Signal,
         Weight_Loading_Signal, Computing_Signal} = '0;
        {Comp_Reset, Weight_Mem_Index_Reset, Input_Mem_Index_Reset, Output_Mem_Index_Reset} = '0;
    endtask

    always @(negedge clk) begin
        rec_t got, req;
        if (mon_en) begin
            got = sample();
            total++;
            if (got.act != '0) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_activity got=%h required=idle", got);
                end else begin
                    req = exp_q.pop_front();
                    if (got !== req) begin
                        bad++;
                        $display("FAIL phase_record got=%h required=%h", got, req);
                    end
                end
            end else if ({got.ia, got.mclr, got.rd, got.wr, got.cs, got.step, got.widx} !== '0) begin
                bad++;
                $display("FAIL idle_outputs got=%h required=quiet", got);
            end
        end
    end

    initial begin
        rec_t r;
        int   abort_at, rst_sel;
        logic [4:0] p, nz;
        Mem_Reset = 1'b0;
        {Comp_Reset, Weight_Mem_Index_Reset, Output_Mem_Index_Reset, Input_Mem_Index_Reset} = '0;
        {Weight_Loading_Signal, Input_Loading_Signal, Output_Loading_Signal,
         Output_Writing_Signal, Computing_Signal} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        r = sample();
        chk("rst_strobes", 64'({r.act, r.ia}), 64'd0);
        chk("rst_enables", 64'({r.rd, r.wr, r.cs}), 64'd0);
        chk("rst_addrs", 64'({r.war, r.waw, r.iar, r.iaw, r.oar, r.oaw}), 64'd0);
        chk("rst_debug", 64'({r.step, r.widx}), 64'd0);
        chk("rst_mem_clear", 64'(r.mclr), 64'b111);
        Mem_Reset = 1'b1;
        #1 chk("mem_clear_before_edge", 64'(Mem_Clear), 64'b111);
        @(posedge clk); #1;
        chk("mem_clear_after_edge", 64'(Mem_Clear), 64'd0);
        mon_en = 1'b1;

        run_op(5'b00001, 5'b00100, -1, -1);   // full compute, input-load pulse ignored while busy
        run_op(5'b00010, 5'b00000, -1, -1);   // weight load
        run_op(5'b00100, 5'b00000, -1, -1);   // input load
        run_op(5'b00001, 5'b00000, 4, -1);    // compute aborted at step 4
        run_op(5'b00100, 5'b00000, -1, 2);    // input load with index restart
        run_op(5'b11111, 5'b11111, -1, -1);   // priority: compute wins
        run_op(5'b11110, 5'b00000, -1, -1);
        run_op(5'b11100, 5'b00000, -1, -1);
        run_op(5'b11000, 5'b00000, -1, 1);
        run_op(5'b10000, 5'b00000, -1, -1);
        for (int t = 0; t < 40; t++) begin
            p        = 5'($urandom_range(1, 31));
            nz       = ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'd0;
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, S - 1)) : -1;
            rst_sel  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_op(p, nz, abort_at, rst_sel);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        repeat (4) @(posedge clk);
        #1 chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
